// File: rtl/hex_display_scanner_pkg.sv
// Shared segment encoding for the hex display path.
// Codes are active-high, {g,f,e,d,c,b,a} with bit 0 = segment a.
package hex_display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] SEG_CODE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
        return SEG_CODE[nibble];
    endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Load/display bundle between the nibble stage, the scanner and the display pins.
interface hex_display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   hex_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      blank_lz;
    logic [6:0]                seg;
    logic                      dp;
    logic [NUM_DIGITS-1:0]     an;
    logic                      update_pending;
    logic                      frame_tick;

    modport master (
        output load, hex_in, dp_in, blank_lz,
        input  seg, dp, an, update_pending, frame_tick
    );

    modport slave (
        input  load, hex_in, dp_in, blank_lz,
        output seg, dp, an, update_pending, frame_tick
    );
endinterface

// File: rtl/hex_display_scanner_seg7.sv
// Combinational nibble to active-high 7-segment decoder.
module hex_to_seg7
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one hex digit.
    always_comb begin
        seg = seg_encode(nibble);
    end

endmodule

// File: rtl/hex_display_scanner.sv
// Multiplexed 7-segment scanner with frame-boundary double buffering.
// Outputs are registered and already carry the board polarity.
module hex_display_scanner
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    hex_display_scanner_if.slave  bus
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(REFRESH_DIV - 2);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_IDLE = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_IDLE  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] disp_hex_r;
    logic [NUM_DIGITS-1:0]   disp_dp_r;
    logic                    disp_blz_r;
    logic [4*NUM_DIGITS-1:0] pend_hex_r;
    logic [NUM_DIGITS-1:0]   pend_dp_r;
    logic                    pend_blz_r;
    logic                    update_pending_r;
    logic                    frame_tick_r;
    logic [6:0]              seg_r;
    logic                    dp_r;
    logic [NUM_DIGITS-1:0]   an_r;

    logic                    slot_end_s;
    logic                    commit_s;
    logic [3:0]              nibble_s;
    logic                    upper_zero_s;
    logic                    blank_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [6:0]              seg_code_s;

    hex_to_seg7 u_dec (
        .nibble (nibble_s),
        .seg    (seg_code_s)
    );

    // Slot/frame boundaries, active nibble and leading-zero test for the scanned digit.
    always_comb begin
        slot_end_s   = (cnt_r == CNT_LAST);
        commit_s     = slot_end_s && (idx_r == IDX_LAST);
        nibble_s     = disp_hex_r[{idx_r, 2'b00} +: 4];
        onehot_s     = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_r;
        upper_zero_s = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((j >= int'(idx_r)) && (disp_hex_r[j*4 +: 4] != 4'h0)) begin
                upper_zero_s = 1'b0;
            end else begin
                upper_zero_s = upper_zero_s;
            end
        end
        blank_s = disp_blz_r && (idx_r != IDX_ZERO) && upper_zero_s;
    end

    // Scan counters, double buffer and frame pulse; a load in the commit cycle bypasses pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r            <= CNT_ZERO;
            idx_r            <= IDX_ZERO;
            disp_hex_r       <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_r        <= {NUM_DIGITS{1'b0}};
            disp_blz_r       <= 1'b0;
            pend_hex_r       <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_r        <= {NUM_DIGITS{1'b0}};
            pend_blz_r       <= 1'b0;
            update_pending_r <= 1'b0;
            frame_tick_r     <= 1'b0;
        end else begin
            cnt_r <= slot_end_s ? CNT_ZERO : cnt_r + 1'b1;
            if (slot_end_s) begin
                idx_r <= (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + 1'b1;
            end
            // Registered one cycle ahead so the pulse coincides with the commit cycle.
            frame_tick_r <= (cnt_r == CNT_PRE) && (idx_r == IDX_LAST);
            if (commit_s && bus.load) begin
                disp_hex_r       <= bus.hex_in;
                disp_dp_r        <= bus.dp_in;
                disp_blz_r       <= bus.blank_lz;
                update_pending_r <= 1'b0;
            end else if (commit_s && update_pending_r) begin
                disp_hex_r       <= pend_hex_r;
                disp_dp_r        <= pend_dp_r;
                disp_blz_r       <= pend_blz_r;
                update_pending_r <= 1'b0;
            end else if (bus.load) begin
                pend_hex_r       <= bus.hex_in;
                pend_dp_r        <= bus.dp_in;
                pend_blz_r       <= bus.blank_lz;
                update_pending_r <= 1'b1;
            end
        end
    end

    // Pin registers; the first cycle of each slot keeps every anode off to avoid ghosting.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_r <= SEG_IDLE;
            dp_r  <= DP_IDLE;
            an_r  <= AN_IDLE;
        end else begin
            seg_r <= (blank_s ? SEG_OFF : seg_code_s) ^ {7{SEG_ACTIVE_LOW}};
            dp_r  <= disp_dp_r[idx_r] ^ SEG_ACTIVE_LOW;
            an_r  <= (cnt_r == CNT_ZERO) ? AN_IDLE : (onehot_s ^ AN_IDLE);
        end
    end

    assign bus.seg            = seg_r;
    assign bus.dp             = dp_r;
    assign bus.an             = an_r;
    assign bus.update_pending = update_pending_r;
    assign bus.frame_tick     = frame_tick_r;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed plus random bench for hex_display_scanner (4 digits, 4 cycles per slot, active-low pins).
module tb_hex_display_scanner;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int FR = ND * RD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hex_display_scanner_if #(.NUM_DIGITS(ND)) bus ();

    hex_display_scanner #(
        .NUM_DIGITS     (ND),
        .REFRESH_DIV    (RD),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: position within the frame, shown value and pending value.
    logic [6:0]  codes [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          pos = 0;
    logic [15:0] sh_hex = 16'h0, pd_hex = 16'h0;
    logic [3:0]  sh_dp = 4'h0, pd_dp = 4'h0;
    bit          sh_blz = 1'b0, pd_blz = 1'b0, pflag = 1'b0;

    function automatic logic [6:0] digit_code(input logic [15:0] hex, input bit blz, input int slot);
        logic [15:0] upper;
        upper = hex >> (4 * slot);
        if (blz && slot > 0 && upper == 16'h0) return 7'h00;
        return codes[upper[3:0]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // One clock: predict pin values, advance the model, compare.
    task automatic cycle();
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] e_an;
        int         slot;
        bit         commit;
        if (rst) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF;
        end else begin
            slot  = pos / RD;
            e_an  = ((pos % RD) == 0) ? 4'hF : (4'hF ^ (4'b0001 << slot));
            e_seg = ~digit_code(sh_hex, sh_blz, slot);
            e_dp  = ~sh_dp[slot];
        end
        commit = (pos == FR - 1);
        @(posedge clk);
        #1;
        if (rst) begin
            pos = 0; sh_hex = 16'h0; sh_dp = 4'h0; sh_blz = 1'b0;
            pd_hex = 16'h0; pd_dp = 4'h0; pd_blz = 1'b0; pflag = 1'b0;
        end else begin
            if (commit) begin
                if (bus.load) begin
                    sh_hex = bus.hex_in; sh_dp = bus.dp_in; sh_blz = bus.blank_lz;
                end else if (pflag) begin
                    sh_hex = pd_hex; sh_dp = pd_dp; sh_blz = pd_blz;
                end
                pflag = 1'b0;
            end else if (bus.load) begin
                pd_hex = bus.hex_in; pd_dp = bus.dp_in; pd_blz = bus.blank_lz; pflag = 1'b1;
            end
            pos = (pos + 1) % FR;
        end
        chk("seg", 32'(bus.seg), 32'(e_seg));
        chk("dp", 32'(bus.dp), 32'(e_dp));
        chk("an", 32'(bus.an), 32'(e_an));
        chk("update_pending", 32'(bus.update_pending), 32'(pflag));
        chk("frame_tick", 32'(bus.frame_tick), 32'(!rst && pos == FR - 1));
    endtask

    task automatic load_val(input logic [15:0] hex, input logic [3:0] dpv, input bit blz);
        bus.load = 1'b1; bus.hex_in = hex; bus.dp_in = dpv; bus.blank_lz = blz;
        cycle();
        bus.load = 1'b0;
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * FR && !seen; i++) begin
            cycle();
            seen = bus.frame_tick;
        end
        chk("wait_tick_timeout", 32'(seen), 32'd1);
    endtask

    task automatic expect_digit(input int slot, input logic [6:0] s, input logic d);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FR && !found; i++) begin
            cycle();
            found = (bus.an == (4'hF ^ (4'b0001 << slot)));
        end
        chk("digit_found", 32'(found), 32'd1);
        chk("digit_seg", 32'(bus.seg), 32'(s));
        chk("digit_dp", 32'(bus.dp), 32'(d));
    endtask

    initial begin
        int n;
        bus.load = 1'b0; bus.hex_in = 16'h0; bus.dp_in = 4'h0; bus.blank_lz = 1'b0;

        // 1. reset, then frame_tick period
        rst = 1'b1;
        repeat (3) cycle();
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_seg", 32'(bus.seg), 32'h7F);
        rst = 1'b0;
        wait_tick();
        n = 0;
        repeat (FR) begin
            cycle();
            n += int'(bus.frame_tick);
        end
        chk("tick_period_last", 32'(bus.frame_tick), 32'd1);
        chk("tick_period_count", 32'(n), 32'd1);

        // 2/3. anode order and a mid-frame load
        repeat (5) cycle();
        load_val(16'h12AF, 4'b0100, 1'b0);
        chk("pending_set", 32'(bus.update_pending), 32'd1);
        wait_tick();
        expect_digit(0, 7'h0E, 1'b1);
        expect_digit(1, 7'h08, 1'b1);
        expect_digit(2, 7'h24, 1'b0);
        expect_digit(3, 7'h79, 1'b1);

        // 4. leading-zero blanking
        load_val(16'h0005, 4'b0000, 1'b1);
        wait_tick();
        expect_digit(0, 7'h12, 1'b1);
        expect_digit(1, 7'h7F, 1'b1);
        expect_digit(2, 7'h7F, 1'b1);
        expect_digit(3, 7'h7F, 1'b1);
        load_val(16'h0000, 4'b0000, 1'b1);
        wait_tick();
        expect_digit(0, 7'h40, 1'b1);
        expect_digit(3, 7'h7F, 1'b1);

        // 5. last write wins, then a load in the commit cycle
        load_val(16'h1111, 4'b0000, 1'b0);
        load_val(16'h2222, 4'b0000, 1'b0);
        wait_tick();
        expect_digit(0, 7'h24, 1'b1);
        expect_digit(3, 7'h24, 1'b1);
        wait_tick();
        load_val(16'h3333, 4'b0000, 1'b0);
        chk("commit_load_no_pending", 32'(bus.update_pending), 32'd0);
        expect_digit(0, 7'h30, 1'b1);
        expect_digit(3, 7'h30, 1'b1);

        // 6. reset mid-frame with a pending value
        repeat (3) cycle();
        load_val(16'h9876, 4'b1111, 1'b0);
        cycle();
        rst = 1'b1;
        bus.load = 1'b1; bus.hex_in = 16'h4444;
        cycle();
        bus.load = 1'b0;
        chk("midrst_pending", 32'(bus.update_pending), 32'd0);
        chk("midrst_dp", 32'(bus.dp), 32'd1);
        rst = 1'b0;
        wait_tick();
        expect_digit(0, 7'h40, 1'b1);
        expect_digit(2, 7'h40, 1'b1);

        // Random loads and occasional resets against the model
        for (int i = 0; i < 800; i++) begin
            rst          = ($urandom_range(0, 199) == 0);
            bus.load     = ($urandom_range(0, 7) == 0);
            bus.hex_in   = 16'($urandom) >> (4 * $urandom_range(0, 4));
            bus.dp_in    = 4'($urandom);
            bus.blank_lz = 1'($urandom);
            cycle();
        end
        rst = 1'b0;
        bus.load = 1'b0;
        repeat (2 * FR) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
